sample_sequencer: RTL

//  Per-sample controller for the ADC -> phase-accumulator -> sine ROM -> DAC/PWM chain.

---
 rtl/dds_pkg.sv | 13 +
 rtl/tick_gen.sv | 35 +++
 rtl/sample_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sample chain: sequencer state encoding and default data width.
package dds_pkg;

    localparam int DW_DEFAULT = 10;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADC_START = 3'd1;
    localparam logic [2:0] ADC_WAIT  = 3'd2;
    localparam logic [2:0] PHASE     = 3'd3;
    localparam logic [2:0] ROM_WAIT  = 3'd4;
    localparam logic [2:0] OUTPUT    = 3'd5;

endpackage

// File: rtl/tick_gen.sv
// Sample-rate divider: one registered tick pulse every DIV cycles while enabled.
module tick_gen #(
    parameter int DIV = 5000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    // Disabling parks the counter at 0 so the next tick is a full period after re-enable.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (!enable) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == CW'(DIV - 1)) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample controller: tick -> ADC conversion -> frequency latch -> phase step -> ROM read -> DAC load.
module sample_sequencer
    import dds_pkg::*;
#(
    parameter int DIV         = 5000,
    parameter int ADC_TIMEOUT = 2000,
    parameter int ROM_LAT     = 1,
    parameter int DW          = DW_DEFAULT
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          enable,
    output logic          sample_tick,
    output logic          adc_start,
    input  logic          adc_data_valid,
    input  logic [DW-1:0] adc_data,
    output logic [DW-1:0] freq_word,
    output logic [DW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] dac_data,
    output logic          dac_load,
    output logic          busy,
    output logic          overrun,
    output logic          adc_timeout
);

    localparam int TW = $clog2(ADC_TIMEOUT + 1);

    logic [2:0]    state_reg, state_next;
    logic [TW-1:0] tmo_reg;
    logic [2:0]    rom_cnt_reg;
    logic          dv_prev_reg;
    logic [DW-1:0] freq_reg, addr_reg, dac_reg;
    logic          overrun_reg, timeout_reg;

    logic dv_edge, tmo_done, rom_done;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .sysclk (sysclk),
        .reset  (reset),
        .enable (enable),
        .tick   (sample_tick)
    );

    // Previous level is tracked every cycle, so a level already high on entry to ADC_WAIT is ignored.
    assign dv_edge  = adc_data_valid & ~dv_prev_reg;
    assign tmo_done = (tmo_reg == TW'(ADC_TIMEOUT - 1));
    assign rom_done = (rom_cnt_reg == 3'(ROM_LAT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (sample_tick) state_next = ADC_START;
            ADC_START: state_next = ADC_WAIT;
            ADC_WAIT:  if (dv_edge || tmo_done) state_next = PHASE;
            PHASE:     state_next = ROM_WAIT;
            ROM_WAIT:  if (rom_done) state_next = OUTPUT;
            OUTPUT:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg   <= IDLE;
            tmo_reg     <= '0;
            rom_cnt_reg <= '0;
            dv_prev_reg <= 1'b0;
            freq_reg    <= '0;
            addr_reg    <= '0;
            dac_reg     <= '0;
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dv_prev_reg <= adc_data_valid;
            if (sample_tick && state_reg != IDLE)
                overrun_reg <= 1'b1;
            case (state_reg)
                ADC_START: tmo_reg <= '0;
                ADC_WAIT: begin
                    if (dv_edge)
                        freq_reg <= adc_data;
                    else if (tmo_done)
                        timeout_reg <= 1'b1;
                    else
                        tmo_reg <= tmo_reg + 1'b1;
                end
                PHASE: begin
                    addr_reg    <= addr_reg + freq_reg;
                    rom_cnt_reg <= '0;
                end
                ROM_WAIT: rom_cnt_reg <= rom_cnt_reg + 1'b1;
                OUTPUT:   dac_reg <= rom_data;
                default: ;
            endcase
        end
    end

    // dac_data shows the new sample during the load cycle itself, then holds it.
    assign dac_data    = (state_reg == OUTPUT) ? rom_data : dac_reg;
    assign dac_load    = (state_reg == OUTPUT);
    assign adc_start   = (state_reg == ADC_START);
    assign busy        = (state_reg != IDLE);
    assign freq_word   = freq_reg;
    assign rom_addr    = addr_reg;
    assign overrun     = overrun_reg;
    assign adc_timeout = timeout_reg;

endmodule
